// File: rtl/hash_writeback_fsm.sv
// Writes a 512-bit hash back to memory as NUM_BEATS 128-bit master write
// transactions, one init pulse / data beat / completion handshake per beat.
module hash_writeback_fsm #(
  parameter int NUM_BEATS  = 4,
  parameter int BASE_INDEX = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] hash_in,
  input  logic         hash_valid,
  output logic         hash_ready,
  output logic [127:0] wr_data,
  output logic         wr_data_valid,
  input  logic         wr_data_req,
  output logic [31:0]  write_addr_index,
  output logic         init_master_txn,
  input  logic         write_done,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0]  LAST_BEAT = 2'(NUM_BEATS - 1);
  localparam logic [31:0] BASE_IDX  = 32'(BASE_INDEX);

  state_t       state_r;
  logic [1:0]   beat_r;
  logic [511:0] shadow_r;

  // Sequencer: every output is assigned for the state being entered, so all
  // outputs come straight from flops and line up with state_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      beat_r           <= 2'd0;
      shadow_r         <= 512'd0;
      hash_ready       <= 1'b1;
      busy             <= 1'b0;
      init_master_txn  <= 1'b0;
      wr_data_valid    <= 1'b0;
      wr_data          <= 128'd0;
      write_addr_index <= BASE_IDX;
      done             <= 1'b0;
    end else begin
      init_master_txn <= 1'b0;
      done            <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hash_valid) begin
            shadow_r         <= hash_in;
            beat_r           <= 2'd0;
            write_addr_index <= BASE_IDX;
            hash_ready       <= 1'b0;
            busy             <= 1'b1;
            init_master_txn  <= 1'b1;
            state_r          <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          // Beat 0 occupies shadow[127:0], so the lower hash word leads.
          wr_data       <= shadow_r[{beat_r, 7'd0} +: 128];
          wr_data_valid <= 1'b1;
          state_r       <= DATA;
        end
        DATA: begin
          if (wr_data_req) begin
            wr_data_valid <= 1'b0;
            state_r       <= WAIT_DONE;
          end else begin
            state_r <= DATA;
          end
        end
        WAIT_DONE: begin
          if (write_done) begin
            if (beat_r == LAST_BEAT) begin
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              beat_r           <= beat_r + 2'd1;
              write_addr_index <= write_addr_index + 32'd1;
              init_master_txn  <= 1'b1;
              state_r          <= START;
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        DONE: begin
          hash_ready <= 1'b1;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          hash_ready    <= 1'b1;
          busy          <= 1'b0;
          wr_data_valid <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hash_writeback_fsm.md
HASH_WRITEBACK_FSM -- requirements
Module: hash_writeback_fsm

Interface
REQ-001 Parameter NUM_BEATS, default 4, is the number of 128-bit write transactions per hash; legal range 1..4.
REQ-002 Parameter BASE_INDEX, default 0, is the write address index of the first beat.
REQ-003 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hash_in  in  512  hash to write back; sampled only on the accept cycle.
REQ-006 hash_valid  in  1  hash_in is valid.
REQ-007 hash_ready  out  1  block can accept a hash.
REQ-008 wr_data  out  128  write beat presented to the bus master.
REQ-009 wr_data_valid  out  1  wr_data is valid.
REQ-010 wr_data_req  in  1  bus master consumes wr_data this cycle.
REQ-011 write_addr_index  out  32  beat index of the current transaction.
REQ-012 init_master_txn  out  1  one-cycle pulse that starts one master write transaction.
REQ-013 write_done  in  1  master reports the current transaction complete.
REQ-014 busy  out  1  a writeback is in progress.
REQ-015 done  out  1  one-cycle pulse when all NUM_BEATS transactions are complete.

Function
REQ-016 The state machine SHALL have exactly these states: IDLE, START, DATA, WAIT_DONE, DONE.
REQ-017 IDLE: hash_ready=1, busy=0; on hash_valid=1, capture hash_in into a 512-bit shadow register, set beat=0, set write_addr_index=BASE_INDEX, and go to START.
REQ-018 START: init_master_txn=1 for exactly this one cycle; next state is DATA.
REQ-019 DATA: wr_data_valid=1 and wr_data=shadow[128*beat+127 : 128*beat]; bits [63:0] of the beat carry the lower-addressed 64-bit hash word.
REQ-020 DATA: on wr_data_req=1, go to WAIT_DONE the next cycle; otherwise hold wr_data and wr_data_valid stable indefinitely.
REQ-021 WAIT_DONE, write_done=1 and beat<NUM_BEATS-1: increment beat and write_addr_index by 1, then go to START.
REQ-022 WAIT_DONE, write_done=1 and beat==NUM_BEATS-1: go to DONE.
REQ-023 DONE: done=1 for one cycle; next state is IDLE, with hash_ready=1 again on the following cycle.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 hash_ready SHALL be 0 outside IDLE; hash_valid outside IDLE is ignored, and the shadow register is not modified.
REQ-026 wr_data_req outside DATA, and write_done outside WAIT_DONE, SHALL be ignored without state change.
REQ-027 wr_data_valid SHALL be 0 outside DATA; wr_data outside DATA is don't-care but SHALL NOT contain X.
REQ-028 write_addr_index SHALL hold its last value after DONE until the next accept reloads BASE_INDEX.
REQ-029 Minimum cost per beat is 3 cycles (START, DATA, WAIT_DONE) when wr_data_req and write_done arrive at the earliest allowed cycles.
REQ-030 Minimum total from the accept cycle to the done pulse is 3*NUM_BEATS+1 cycles.

Reset
REQ-031 On reset, the block SHALL enter IDLE with init_master_txn=0, wr_data_valid=0, done=0, busy=0, hash_ready=1, write_addr_index=BASE_INDEX, beat=0, shadow=0, wr_data=0.
REQ-032 Reset in any state SHALL abort the writeback immediately; no further init_master_txn or done pulse occurs for the aborted hash.

Verification
REQ-033 Single hash, hash_in = {0x...3,0x...2,0x...1,0x...0} (128-bit beats), master responds immediately -> four init pulses at index 0,1,2,3; wr_data beats 0..3 in order; done pulse 13 cycles after accept.
REQ-034 Slow master: wr_data_req delayed 5 cycles and write_done delayed 7 cycles per beat -> wr_data held stable while waiting; exactly one init pulse per beat; no beat skipped or repeated.
REQ-035 hash_valid pulsed again mid-writeback with a different value -> ignored; all four beats carry the first hash; hash_ready stays 0 until DONE completes.
REQ-036 Spurious inputs: write_done in DATA and wr_data_req in WAIT_DONE -> no state change; beat count unaffected.
REQ-037 Reset asserted in WAIT_DONE of beat 2 -> next cycle IDLE, hash_ready=1, write_addr_index=BASE_INDEX; a new hash then completes normally.
REQ-038 NUM_BEATS=1 and BASE_INDEX=8 -> a single transaction at index 8 with beat [127:0]; done pulse 4 cycles after accept.
